// File: rtl/dac_sample_feeder_if.sv
`default_nettype none
// ============================================================================
// dac_sample_feeder_if : producer push port plus DAC start/busy handshake. Rev 1.0
// ============================================================================
interface dac_sample_feeder_if #(
  parameter int DATA_W = 16
) ();
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] dac_data;
  logic              dac_start;
  logic              dac_busy;

  // master: the feeder itself; slave: producer and serializer around it
  modport master (
    input  in_data, in_valid, dac_busy,
    output in_ready, dac_data, dac_start
  );
  modport slave (
    output in_data, in_valid, dac_busy,
    input  in_ready, dac_data, dac_start
  );
endinterface
`default_nettype wire

// File: rtl/dac_sample_feeder.sv
`default_nettype none
// ============================================================================
// dac_sample_feeder : FIFO-buffered, rate-paced word source for a DAC serializer.
// Option macro DAC_FEEDER_UNDERFLOW_CNT_EN adds a saturating underflow_cnt. Rev 1.0
// ============================================================================
module dac_sample_feeder #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  dac_sample_feeder_if.master         bus,
  input  logic                        enable,
  input  logic [DIV_W-1:0]            rate_div,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        underflow,
  output logic                        missed_tick
`ifdef DAC_FEEDER_UNDERFLOW_CNT_EN
  ,
  output logic [15:0]                 underflow_cnt
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [LW-1:0]     level;
  logic [DIV_W-1:0]  cnt;
  logic [DATA_W-1:0] dac_data_r;
  logic              dac_start_r;
  logic              underflow_r, missed_r;
  logic              full, empty, push, pop, tick;
  logic              start_nxt, underflow_nxt, missed_nxt;

  assign full         = (level == FULL_LEVEL);
  assign empty        = (level == '0);
  assign bus.in_ready = !rst && !full;
  assign push         = bus.in_valid && bus.in_ready;
  assign tick         = enable && (cnt == '0);

  assign bus.dac_data  = dac_data_r;
  assign bus.dac_start = dac_start_r;
  assign fifo_level    = level;
  assign underflow     = underflow_r;
  assign missed_tick   = missed_r;

  // Held at rate_div while disabled, so the first tick lands rate_div cycles after enable
  always_ff @(posedge clk) begin
    if (rst || !enable || cnt == '0) begin
      cnt <= rate_div;
    end else begin
      cnt <= cnt - DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        level <= level + LW'(1);
      end else if (pop && !push) begin
        level <= level - LW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    pop           = 1'b0;
    start_nxt     = 1'b0;
    underflow_nxt = 1'b0;
    missed_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (tick) begin
          pop           = !empty;
          underflow_nxt = empty;
          start_nxt     = 1'b1;
          state_nxt     = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        missed_nxt = tick;
        if (bus.dac_busy) begin
          state_nxt = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        missed_nxt = tick;
        if (!bus.dac_busy) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // On underflow dac_data is left alone, so the serializer repeats the last word
  always_ff @(posedge clk) begin
    if (rst) begin
      dac_data_r  <= '0;
      dac_start_r <= 1'b0;
      underflow_r <= 1'b0;
      missed_r    <= 1'b0;
    end else begin
      if (pop) begin
        dac_data_r <= mem[rd_ptr];
      end
      dac_start_r <= start_nxt;
      underflow_r <= underflow_nxt;
      missed_r    <= missed_nxt;
    end
  end

`ifdef DAC_FEEDER_UNDERFLOW_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      underflow_cnt <= '0;
    end else if (underflow_nxt && underflow_cnt != 16'hFFFF) begin
      underflow_cnt <= underflow_cnt + 16'd1;
    end
  end
`endif
endmodule
`default_nettype wire

// File: tb/tb_dac_sample_feeder.sv
`default_nettype none
// tb_dac_sample_feeder : randomized bench; a queue-based model predicts every output each cycle,
// directed scenarios add explicit checks against constants taken from the block's behaviour.
module tb_dac_sample_feeder;
  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int DIVW  = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            enable;
  logic [DIVW-1:0] rate_div;
  logic [3:0]      fifo_level;
  logic            underflow, missed_tick;
`ifdef DAC_FEEDER_UNDERFLOW_CNT_EN
  logic [15:0]     underflow_cnt;
`endif
  int checks = 0;
  int errors = 0;
  int busy_len = 4;
  int ser_cnt = 0;

  dac_sample_feeder_if #(.DATA_W(DW)) bus ();

  dac_sample_feeder #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .DIV_W(DIVW)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .enable      (enable),
    .rate_div    (rate_div),
    .fifo_level  (fifo_level),
    .underflow   (underflow),
`ifdef DAC_FEEDER_UNDERFLOW_CNT_EN
    .underflow_cnt (underflow_cnt),
`endif
    .missed_tick (missed_tick)
  );

  always #5 clk = ~clk;

  // Serializer: busy for busy_len cycles starting the cycle after a start
  always @(posedge clk) begin
    if (rst) ser_cnt <= 0;
    else if (bus.dac_start) ser_cnt <= busy_len;
    else if (ser_cnt != 0) ser_cnt <= ser_cnt - 1;
  end
  assign bus.dac_busy = (ser_cnt != 0);

  // Reference model: word queue, tick countdown and an in-flight flag
  logic [DW-1:0] mq[$];
  int            m_cnt = 0;
  bit            m_inflight = 0, m_seen = 0;
  logic          e_start = 0, e_under = 0, e_missed = 0;
  logic [DW-1:0] e_data = '0;
  logic [15:0]   e_ucnt = '0;

  always @(posedge clk) begin : model
    int sz0;
    bit tk;
    if (rst) begin
      mq.delete();
      m_cnt = int'(rate_div);
      m_inflight = 0; m_seen = 0;
      e_start = 0; e_under = 0; e_missed = 0; e_data = '0; e_ucnt = '0;
    end else begin
      sz0 = mq.size();
      tk = enable && (m_cnt == 0);
      e_start = 0; e_under = 0; e_missed = 0;
      if (m_inflight) begin
        if (tk) e_missed = 1;
        if (!m_seen) begin
          if (bus.dac_busy) m_seen = 1;
        end else if (!bus.dac_busy) begin
          m_inflight = 0; m_seen = 0;
        end
      end else if (tk) begin
        if (sz0 > 0) e_data = mq.pop_front();
        else begin
          e_under = 1;
          if (e_ucnt != 16'hFFFF) e_ucnt = e_ucnt + 16'd1;
        end
        e_start = 1; m_inflight = 1; m_seen = 0;
      end
      if (bus.in_valid && sz0 < DEPTH) mq.push_back(bus.in_data);
      if (!enable || m_cnt == 0) m_cnt = int'(rate_div);
      else m_cnt = m_cnt - 1;
    end
  end

  logic [23:0] dut_vec;
  assign dut_vec = {bus.dac_start, underflow, missed_tick, bus.dac_data, fifo_level, bus.in_ready};

  function automatic logic [23:0] exp_vec();
    return {e_start, e_under, e_missed, e_data, 4'(mq.size()), (!rst && (mq.size() < DEPTH))};
  endfunction

  task automatic test_reset();
    rst = 1; enable = 0; rate_div = 16'd9; busy_len = 34;
    bus.in_valid = 0; bus.in_data = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (dut_vec !== 24'h0) begin errors++; $display("FAIL reset_state got %h exp %h", dut_vec, 24'h0); end
`ifdef DAC_FEEDER_UNDERFLOW_CNT_EN
    checks++;
    if (underflow_cnt !== 16'd0) begin errors++; $display("FAIL reset_ucnt got %h exp 0", underflow_cnt); end
`endif
    rst = 0;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || fifo_level !== 4'd0) begin
      errors++; $display("FAIL reset_release got ready %b level %0d exp ready 1 level 0", bus.in_ready, fifo_level);
    end
  endtask

  task automatic test_basic();
    logic [DW-1:0] words [3];
    logic [DW-1:0] got[$];
    words = '{16'h1111, 16'h2222, 16'h3333};
    rate_div = 16'd9; busy_len = 34; enable = 0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1; bus.in_data = words[i];
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL basic_push got %h exp %h", dut_vec, exp_vec()); end
    end
    checks++;
    if (fifo_level !== 4'd3) begin errors++; $display("FAIL basic_level3 got %0d exp 3", fifo_level); end
    bus.in_valid = 0; enable = 1;
    for (int c = 0; c < 160; c++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL basic_run cyc %0d got %h exp %h", c, dut_vec, exp_vec()); end
      if (bus.dac_start && got.size() < 3) got.push_back(bus.dac_data);
    end
    checks++;
    if (got.size() != 3) begin errors++; $display("FAIL basic_starts got %0d exp 3", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i] !== words[i]) begin errors++; $display("FAIL basic_word%0d got %h exp %h", i, got[i], words[i]); end
    end
    checks++;
    if (fifo_level !== 4'd0) begin errors++; $display("FAIL basic_level0 got %0d exp 0", fifo_level); end
  endtask

  task automatic test_underflow();
    int n_start = 0;
    rst = 1; enable = 0; rate_div = 16'd4; busy_len = 5; bus.in_valid = 0;
    @(negedge clk);
    rst = 0; bus.in_valid = 1; bus.in_data = 16'hABCD;
    @(negedge clk);
    checks++;
    if (dut_vec !== exp_vec()) begin errors++; $display("FAIL uflow_push got %h exp %h", dut_vec, exp_vec()); end
    bus.in_valid = 0; enable = 1;
    for (int c = 0; c < 200 && n_start < 2; c++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL uflow_run cyc %0d got %h exp %h", c, dut_vec, exp_vec()); end
      if (bus.dac_start) begin
        n_start++;
        checks++;
        if (underflow !== (n_start == 2) || bus.dac_data !== 16'hABCD) begin
          errors++; $display("FAIL uflow_start%0d got under %b data %h exp under %b data abcd", n_start, underflow, bus.dac_data, n_start == 2);
        end
      end
    end
    checks++;
    if (n_start < 2) begin errors++; $display("FAIL uflow_timeout got %0d starts exp 2", n_start); end
`ifdef DAC_FEEDER_UNDERFLOW_CNT_EN
    checks++;
    if (underflow_cnt !== 16'd1) begin errors++; $display("FAIL uflow_cnt got %0d exp 1", underflow_cnt); end
`endif
    @(negedge clk);
    checks++;
    if (underflow !== 1'b0) begin errors++; $display("FAIL uflow_pulse got %b exp 0", underflow); end
  endtask

  task automatic test_full();
    bit seen = 0;
    enable = 0; rate_div = 16'd0; busy_len = 3; bus.in_valid = 0;
    repeat (40) @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      bus.in_valid = 1; bus.in_data = (i < 8) ? 16'h5000 + 16'(i) : 16'h5008;
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL full_fill cyc %0d got %h exp %h", i, dut_vec, exp_vec()); end
    end
    checks++;
    if (fifo_level !== 4'd8 || bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL full_block got level %0d ready %b exp 8 0", fifo_level, bus.in_ready);
    end
    enable = 1;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL full_pop cyc %0d got %h exp %h", c, dut_vec, exp_vec()); end
      seen = bus.dac_start;
    end
    checks++;
    if (!seen || fifo_level !== 4'd7 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL full_after_pop got start %b level %0d ready %b exp 1 7 1", seen, fifo_level, bus.in_ready);
    end
    @(negedge clk);
    checks++;
    if (fifo_level !== 4'd8) begin errors++; $display("FAIL full_ninth got level %0d exp 8", fifo_level); end
    bus.in_valid = 0;
  endtask

  task automatic test_missed();
    int n_missed = 0, n_start = 0;
    rate_div = 16'd3; busy_len = 20; enable = 1;
    for (int c = 0; c < 250; c++) begin
      bus.in_valid = ($urandom_range(3) == 0); bus.in_data = 16'($urandom);
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL missed_run cyc %0d got %h exp %h", c, dut_vec, exp_vec()); end
      n_missed += int'(missed_tick);
      n_start += int'(bus.dac_start);
    end
    bus.in_valid = 0;
    checks++;
    if (n_missed < n_start || n_start < 3) begin
      errors++; $display("FAIL missed_count got missed %0d starts %0d exp missed >= starts >= 3", n_missed, n_start);
    end
  endtask

  task automatic test_reset_mid();
    bit in_done = 0;
    rst = 1; enable = 0; rate_div = 16'd2; busy_len = 10;
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1; bus.in_data = 16'h7700 + 16'(i);
      @(negedge clk);
    end
    bus.in_valid = 0; enable = 1;
    for (int c = 0; c < 100 && !in_done; c++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL rmid_run cyc %0d got %h exp %h", c, dut_vec, exp_vec()); end
      in_done = m_inflight && m_seen;
    end
    checks++;
    if (!in_done || fifo_level !== 4'd4) begin errors++; $display("FAIL rmid_setup got done %b level %0d exp 1 4", in_done, fifo_level); end
    rst = 1;
    @(negedge clk);
    checks++;
    if (dut_vec !== 24'h0) begin errors++; $display("FAIL rmid_reset got %h exp %h", dut_vec, 24'h0); end
    rst = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL rmid_after cyc %0d got %h exp %h", c, dut_vec, exp_vec()); end
      if (c < 2) begin
        checks++;
        if (bus.dac_start !== 1'b0) begin errors++; $display("FAIL rmid_nostart cyc %0d got 1 exp 0", c); end
      end
    end
  endtask

  task automatic test_enable_drop();
    bit seen = 0;
    int n_start = 0, k = 0;
    enable = 0; rate_div = 16'd5; busy_len = 6;
    repeat (30) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1; bus.in_data = 16'h9900 + 16'(i);
      @(negedge clk);
    end
    bus.in_valid = 0; enable = 1;
    for (int c = 0; c < 30 && !seen; c++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL edrop_first cyc %0d got %h exp %h", c, dut_vec, exp_vec()); end
      seen = bus.dac_start;
    end
    enable = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL edrop_idle cyc %0d got %h exp %h", c, dut_vec, exp_vec()); end
      n_start += int'(bus.dac_start);
    end
    checks++;
    if (!seen || n_start != 0) begin errors++; $display("FAIL edrop_quiet got first %b starts %0d exp 1 0", seen, n_start); end
    enable = 1;
    for (int c = 1; c <= 30 && k == 0; c++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL edrop_reen cyc %0d got %h exp %h", c, dut_vec, exp_vec()); end
      if (bus.dac_start) k = c;
    end
    checks++;
    if (k != int'(rate_div) + 1) begin errors++; $display("FAIL edrop_latency got %0d exp %0d", k, int'(rate_div) + 1); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      if (c % 100 == 0) begin
        rate_div = 16'($urandom_range(6));
        busy_len = int'($urandom_range(12, 1));
      end
      bus.in_valid = $urandom_range(1);
      bus.in_data = 16'($urandom);
      if ($urandom_range(19) == 0) enable = ~enable;
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL random cyc %0d got %h exp %h", c, dut_vec, exp_vec()); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underflow();
    test_full();
    test_missed();
    test_reset_mid();
    test_enable_drop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
